page_rank: RTL and testbench
============================

# page_rank

Fixed-point PageRank accelerator over an in-edge CSR graph in host memory. Host software programs the graph geometry through the SoftReg interface, then kicks off the run. The block runs a fixed number of iterations over a 512-bit AXI4 master port, ping-ponging rank arrays between two write buffers. A SoftReg read of the DONE_ALL register returns the sum of the final ranks.

## Interface
- ITERS, 10: PageRank iterations.
- DAMP, 32'hD99A: damping factor d in Q16.16 (≈0.85).
- BASE, 32'h2666: (1-d) in Q16.16.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- AXI read address: arid_m[15:0], araddr_m[63:0], arlen_m[7:0], arsize_m[2:0], arvalid_m out; arready_m in.
- AXI read data: rid_m[15:0], rdata_m[511:0], rresp_m[1:0], rlast_m, rvalid_m in; rready_m out.
- AXI write address: awid_m[15:0], awaddr_m[63:0], awlen_m[7:0], awsize_m[2:0], awvalid_m out; awready_m in.
- AXI write data: wid_m[15:0], wdata_m[511:0], wstrb_m[63:0], wlast_m, wvalid_m out; wready_m in.
- AXI write response: bid_m[15:0], bresp_m[1:0], bvalid_m in; bready_m out.
- softreg_req_valid, softreg_req_isWrite  in  1; softreg_req_addr  in  32; softreg_req_data  in  64.
- softreg_resp_valid  out  1; softreg_resp_data  out  64.

## Operation
- SoftReg write addresses: N_VERT=0x00, N_INEDGES=0x08, VADDR=0x10, IEADDR=0x18, WRITE_ADDR0=0x20, WRITE_ADDR1=0x28, DONE_READ_PARAMS=0x30 (any data; starts run). DONE_ALL=0x38 is read-only.
- Memory layout (byte addresses): vertex v record at VADDR+8v, 64-bit: [31:0] exclusive end index of v's in-edges (start = previous record's end, 0 for v=0), [63:32] inv_outdeg Q16.16 (0 for sinks). In-edge i at IEADDR+4i: 32-bit source vertex id. Rank r[v] at WADDR+4v, 32-bit Q16.16.
- Iteration k (0..ITERS-1) writes buffer k%2; reads ranks from buffer (k-1)%2; k=0 uses r=0x10000 for all sources with no rank read.
- Per vertex v: acc=0 (48-bit); for each in-edge: read edge id u, read vertex[u], read r[u] (k>0); acc += (r[u]*inv_outdeg[u])>>16. Then new = BASE + ((DAMP*acc)>>16), truncated to 32 bits; write to r[v].
- Last iteration also accumulates total = Σ new (64-bit).
- FSM: IDLE → V_READ → E_READ → SRC_READ → RANK_READ → ACCUM (loop per edge) → WRITE → next vertex / next iteration → DONE. DONE holds until reset; new DONE_READ_PARAMS ignored outside IDLE.
- DONE_ALL read: pending until DONE, then one-cycle softreg_resp_valid with data=total; immediate if already DONE.
- N_VERT=0: straight to DONE, total=0.

## Timing
- Reset: all AXI valid/ready outputs 0, softreg_resp_valid 0, data 0, FSM IDLE, registers 0; reset mid-run aborts immediately, no pending AXI completion.
- Every access single beat: arlen/awlen=0, arsize/awsize=3'b110, ids 0, address 64-byte aligned (low 6 bits cleared), wlast=1.
- Read: arvalid held until arready; then rready=1 until rvalid. Word select by addr[5:0]: 32-bit from rdata[addr[5:2]*32+:32], 64-bit from rdata[addr[5:3]*64+:64].
- Write: awvalid and wvalid raised together, each dropped after its own handshake; then bready=1 until bvalid. wstrb = 4'hF << addr[5:0]; data replicated on all lanes.
- Only one outstanding transaction; rresp/bresp ignored.
- SoftReg writes take effect the cycle after request; register write and DONE coinciding are independent.

## Configuration
- PR_READBACK_EN defined: SoftReg read of 0x00–0x28 returns stored value with resp_valid next cycle. Undefined: such reads return 0 next cycle. DONE_ALL behaviour unchanged either way.

## Test plan
- Two vertices, edges 1→0, 0→1, inv_outdeg 0x10000, ITERS=10 → DONE_ALL = 0x20000.
- Single vertex, no edges → rank 0x2666, DONE_ALL = 0x2666; buffer (ITERS-1)%2 holds it.
- DONE_ALL read issued before DONE → no resp until DONE, then exactly one pulse with total.
- Check AXI: arlen=0, arsize=6, aligned araddr, wstrb=0xF0 for WADDR+4 in a 64B line; arready stalled 5 cycles → arvalid held stable.
- Assert rst low mid-ITER → all outputs 0 next edge; rerun after release gives same total as clean run.
- PR_READBACK_EN: write N_VERT=10, read 0x00 → resp 10; undefined → 0.

Source files
------------

// File: rtl/page_rank.sv
// page_rank: fixed-point PageRank engine over an in-edge CSR graph using single-beat AXI4 accesses.
// Define PR_READBACK_EN to make SoftReg reads of the configuration registers return their contents.
`timescale 1ns/1ps
module page_rank #(
    parameter int unsigned ITERS = 10,
    parameter logic [31:0] DAMP  = 32'hD99A,
    parameter logic [31:0] BASE  = 32'h2666
) (
    input  logic         clk,
    input  logic         rst,
    output logic [15:0]  arid_m,
    output logic [63:0]  araddr_m,
    output logic [7:0]   arlen_m,
    output logic [2:0]   arsize_m,
    output logic         arvalid_m,
    input  logic         arready_m,
    input  logic [15:0]  rid_m,
    input  logic [511:0] rdata_m,
    input  logic [1:0]   rresp_m,
    input  logic         rlast_m,
    input  logic         rvalid_m,
    output logic         rready_m,
    output logic [15:0]  awid_m,
    output logic [63:0]  awaddr_m,
    output logic [7:0]   awlen_m,
    output logic [2:0]   awsize_m,
    output logic         awvalid_m,
    input  logic         awready_m,
    output logic [15:0]  wid_m,
    output logic [511:0] wdata_m,
    output logic [63:0]  wstrb_m,
    output logic         wlast_m,
    output logic         wvalid_m,
    input  logic         wready_m,
    input  logic [15:0]  bid_m,
    input  logic [1:0]   bresp_m,
    input  logic         bvalid_m,
    output logic         bready_m,
    input  logic         softreg_req_valid,
    input  logic         softreg_req_isWrite,
    input  logic [31:0]  softreg_req_addr,
    input  logic [63:0]  softreg_req_data,
    output logic         softreg_resp_valid,
    output logic [63:0]  softreg_resp_data
);
    localparam logic [31:0] A_N_VERT    = 32'h00;
    localparam logic [31:0] A_N_INEDGES = 32'h08;
    localparam logic [31:0] A_VADDR     = 32'h10;
    localparam logic [31:0] A_IEADDR    = 32'h18;
    localparam logic [31:0] A_WADDR0    = 32'h20;
    localparam logic [31:0] A_WADDR1    = 32'h28;
    localparam logic [31:0] A_START     = 32'h30;
    localparam logic [31:0] A_DONE_ALL  = 32'h38;
    localparam logic [31:0] RANK_ONE    = 32'h0001_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_V_READ, S_E_READ, S_SRC_READ, S_RANK_READ, S_ACCUM, S_WRITE, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_ISSUE, PH_ADDR, PH_DATA} phase_t;

    state_t      state;
    phase_t      ph;
    logic [63:0] n_vert, n_inedges, vaddr, ieaddr, waddr0, waddr1;
    logic [31:0] iter, vtx, e_idx, end_idx, prev_end, u_id, inv_u, r_u;
    logic [47:0] acc;
    logic [63:0] total;
    logic [3:0]  off;
    logic        done_pend;

    logic [63:0] mem_addr, rd_val;
    logic [31:0] word32, new_rank;
    logic [63:0] word64;
    logic [47:0] contrib;
    logic        start_req;
    logic        unused_inputs;

    assign arid_m   = '0;
    assign arlen_m  = '0;
    assign arsize_m = 3'b110;
    assign awid_m   = '0;
    assign awlen_m  = '0;
    assign awsize_m = 3'b110;
    assign wid_m    = '0;
    assign wlast_m  = 1'b1;

    assign unused_inputs = ^{rid_m, rresp_m, rlast_m, bid_m, bresp_m, n_vert[63:32], n_inedges};

    // Word extraction from the returned 64-byte line using the saved offset
    assign word32 = rdata_m[{off, 5'd0} +: 32];
    assign word64 = rdata_m[{off[3:1], 6'd0} +: 64];

    assign contrib  = 48'((64'(r_u) * 64'(inv_u)) >> 16);
    assign new_rank = BASE + 32'((80'(DAMP) * 80'(acc)) >> 16);
    assign start_req = softreg_req_valid && softreg_req_isWrite && (softreg_req_addr == A_START);

    // Byte address of the access belonging to the current state; k reads buffer (k-1)%2, writes k%2
    always_comb begin
        mem_addr = '0;
        case (state)
            S_V_READ:    mem_addr = vaddr + (64'(vtx) << 3);
            S_E_READ:    mem_addr = ieaddr + (64'(e_idx) << 2);
            S_SRC_READ:  mem_addr = vaddr + (64'(u_id) << 3);
            S_RANK_READ: mem_addr = (iter[0] ? waddr0 : waddr1) + (64'(u_id) << 2);
            S_WRITE:     mem_addr = (iter[0] ? waddr1 : waddr0) + (64'(vtx) << 2);
            default:     mem_addr = '0;
        endcase
    end

`ifdef PR_READBACK_EN
    always_comb begin
        rd_val = '0;
        case (softreg_req_addr)
            A_N_VERT:    rd_val = n_vert;
            A_N_INEDGES: rd_val = n_inedges;
            A_VADDR:     rd_val = vaddr;
            A_IEADDR:    rd_val = ieaddr;
            A_WADDR0:    rd_val = waddr0;
            A_WADDR1:    rd_val = waddr1;
            default:     rd_val = '0;
        endcase
    end
`else
    assign rd_val = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;  ph <= PH_ISSUE;
            n_vert <= '0;  n_inedges <= '0;  vaddr <= '0;  ieaddr <= '0;  waddr0 <= '0;  waddr1 <= '0;
            iter <= '0;  vtx <= '0;  e_idx <= '0;  end_idx <= '0;  prev_end <= '0;
            u_id <= '0;  inv_u <= '0;  r_u <= '0;  acc <= '0;  total <= '0;  off <= '0;
            done_pend <= 1'b0;
            araddr_m <= '0;  arvalid_m <= 1'b0;  rready_m <= 1'b0;
            awaddr_m <= '0;  awvalid_m <= 1'b0;  wdata_m <= '0;  wstrb_m <= '0;  wvalid_m <= 1'b0;
            bready_m <= 1'b0;
            softreg_resp_valid <= 1'b0;  softreg_resp_data <= '0;
        end else begin
            softreg_resp_valid <= 1'b0;
            if (softreg_req_valid && softreg_req_isWrite) begin
                case (softreg_req_addr)
                    A_N_VERT:    n_vert    <= softreg_req_data;
                    A_N_INEDGES: n_inedges <= softreg_req_data;
                    A_VADDR:     vaddr     <= softreg_req_data;
                    A_IEADDR:    ieaddr    <= softreg_req_data;
                    A_WADDR0:    waddr0    <= softreg_req_data;
                    A_WADDR1:    waddr1    <= softreg_req_data;
                    default: ;
                endcase
            end
            // DONE_ALL waits for completion; a fresh request takes the response slot first
            if (softreg_req_valid && !softreg_req_isWrite) begin
                if (softreg_req_addr == A_DONE_ALL) begin
                    if (state == S_DONE) begin
                        softreg_resp_valid <= 1'b1;
                        softreg_resp_data  <= total;
                    end else begin
                        done_pend <= 1'b1;
                    end
                end else begin
                    softreg_resp_valid <= 1'b1;
                    softreg_resp_data  <= rd_val;
                end
            end else if (done_pend && state == S_DONE) begin
                softreg_resp_valid <= 1'b1;
                softreg_resp_data  <= total;
                done_pend          <= 1'b0;
            end

            case (state)
                S_IDLE: if (start_req) begin
                    iter <= '0;  vtx <= '0;  prev_end <= '0;  acc <= '0;  total <= '0;
                    state <= (n_vert[31:0] == 32'd0) ? S_DONE : S_V_READ;
                end
                S_V_READ, S_E_READ, S_SRC_READ, S_RANK_READ: begin
                    case (ph)
                        PH_ISSUE: begin
                            arvalid_m <= 1'b1;
                            araddr_m  <= {mem_addr[63:6], 6'd0};
                            off       <= mem_addr[5:2];
                            ph        <= PH_ADDR;
                        end
                        PH_ADDR: if (arready_m) begin
                            arvalid_m <= 1'b0;
                            rready_m  <= 1'b1;
                            ph        <= PH_DATA;
                        end
                        default: if (rvalid_m) begin
                            rready_m <= 1'b0;
                            ph       <= PH_ISSUE;
                            case (state)
                                S_V_READ: begin
                                    end_idx <= word64[31:0];
                                    e_idx   <= prev_end;
                                    acc     <= '0;
                                    state   <= (prev_end < word64[31:0]) ? S_E_READ : S_WRITE;
                                end
                                S_E_READ: begin
                                    u_id  <= word32;
                                    state <= S_SRC_READ;
                                end
                                S_SRC_READ: begin
                                    inv_u <= word64[63:32];
                                    if (iter == 32'd0) begin
                                        r_u   <= RANK_ONE;
                                        state <= S_ACCUM;
                                    end else begin
                                        state <= S_RANK_READ;
                                    end
                                end
                                default: begin
                                    r_u   <= word32;
                                    state <= S_ACCUM;
                                end
                            endcase
                        end
                    endcase
                end
                S_ACCUM: begin
                    acc   <= acc + contrib;
                    e_idx <= e_idx + 32'd1;
                    state <= (e_idx + 32'd1 < end_idx) ? S_E_READ : S_WRITE;
                end
                S_WRITE: begin
                    case (ph)
                        PH_ISSUE: begin
                            awvalid_m <= 1'b1;
                            wvalid_m  <= 1'b1;
                            awaddr_m  <= {mem_addr[63:6], 6'd0};
                            wstrb_m   <= 64'hF << mem_addr[5:0];
                            wdata_m   <= {16{new_rank}};
                            ph        <= PH_ADDR;
                        end
                        PH_ADDR: begin
                            if (awready_m) awvalid_m <= 1'b0;
                            if (wready_m)  wvalid_m  <= 1'b0;
                            if ((!awvalid_m || awready_m) && (!wvalid_m || wready_m)) begin
                                bready_m <= 1'b1;
                                ph       <= PH_DATA;
                            end
                        end
                        default: if (bvalid_m) begin
                            bready_m <= 1'b0;
                            ph       <= PH_ISSUE;
                            prev_end <= end_idx;
                            if (iter == ITERS - 32'd1) total <= total + 64'(new_rank);
                            if (vtx + 32'd1 < n_vert[31:0]) begin
                                vtx   <= vtx + 32'd1;
                                state <= S_V_READ;
                            end else if (iter + 32'd1 < ITERS) begin
                                iter     <= iter + 32'd1;
                                vtx      <= '0;
                                prev_end <= '0;
                                state    <= S_V_READ;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_page_rank.sv
// tb_page_rank: scoreboard bench for page_rank with a single-beat AXI memory model and a reference PageRank.
`timescale 1ns/1ps
module tb_page_rank;
    localparam int unsigned ITERS = 10;
    localparam logic [63:0] VADDR  = 64'h1000;
    localparam logic [63:0] IEADDR = 64'h2000;
    localparam logic [63:0] WADDR0 = 64'h3000;
    localparam logic [63:0] WADDR1 = 64'h4000;
    localparam logic [63:0] RES_BUF = (((ITERS - 1) % 2) == 1) ? WADDR1 : WADDR0;
`ifdef PR_READBACK_EN
    localparam logic [63:0] RB_EXP = 64'd10;
`else
    localparam logic [63:0] RB_EXP = 64'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]  arid_m, rid_m, awid_m, wid_m, bid_m;
    logic [63:0]  araddr_m, awaddr_m, wstrb_m;
    logic [7:0]   arlen_m, awlen_m;
    logic [2:0]   arsize_m, awsize_m;
    logic         arvalid_m, arready_m, rlast_m, rvalid_m, rready_m;
    logic         awvalid_m, awready_m, wlast_m, wvalid_m, wready_m, bvalid_m, bready_m;
    logic [511:0] rdata_m, wdata_m;
    logic [1:0]   rresp_m, bresp_m;
    logic         softreg_req_valid, softreg_req_isWrite, softreg_resp_valid;
    logic [31:0]  softreg_req_addr;
    logic [63:0]  softreg_req_data, softreg_resp_data;

    page_rank dut (
        .clk(clk), .rst(rst),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
        .awvalid_m(awvalid_m), .awready_m(awready_m),
        .wid_m(wid_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m),
        .wvalid_m(wvalid_m), .wready_m(wready_m),
        .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
        .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
        .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
        .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Host memory, word addressed
    logic [31:0] mem [logic [63:0]];

    function automatic logic [31:0] rd_word(input logic [63:0] wa);
        return mem.exists(wa) ? mem[wa] : 32'h0;
    endfunction

    // Graph description and reference model
    int unsigned g_n;
    logic [31:0] g_end[8], g_inv[8], g_edge[16];
    logic [31:0] m_rank[8];
    logic [63:0] m_total;

    task automatic load_graph();
        mem.delete();
        for (int v = 0; v < int'(g_n); v++) begin
            mem[(VADDR >> 2) + 64'(2 * v)]     = g_end[v];
            mem[(VADDR >> 2) + 64'(2 * v + 1)] = g_inv[v];
        end
        if (g_n > 0)
            for (int i = 0; i < int'(g_end[g_n - 1]); i++) mem[(IEADDR >> 2) + 64'(i)] = g_edge[i];
    endtask

    task automatic run_model();
        logic [31:0] rold[8];
        logic [31:0] rnew[8];
        logic [47:0] acc;
        logic [95:0] p;
        logic [31:0] ru;
        int st;
        m_total = '0;
        for (int k = 0; k < int'(ITERS); k++) begin
            st = 0;
            for (int v = 0; v < int'(g_n); v++) begin
                acc = '0;
                for (int i = st; i < int'(g_end[v]); i++) begin
                    ru  = (k == 0) ? 32'h10000 : rold[g_edge[i]];
                    p   = 96'(ru) * 96'(g_inv[g_edge[i]]);
                    acc = acc + 48'(p >> 16);
                end
                p = 96'(32'hD99A) * 96'(acc);
                rnew[v] = 32'h2666 + 32'(p >> 16);
                st = int'(g_end[v]);
                if (k == int'(ITERS) - 1) m_total = m_total + 64'(rnew[v]);
            end
            for (int v = 0; v < 8; v++) rold[v] = rnew[v];
        end
        for (int v = 0; v < 8; v++) m_rank[v] = rnew[v];
    endtask

    // AXI slave: handshakes decided at negedge take effect on the following posedge
    logic ar_hs, ar_wait, r_hs, aw_hs, w_hs, b_hs, rd_busy, aw_got, w_got, f0_seen;
    logic [63:0]  ar_addr_s, rd_addr, aw_addr_s, w_strb_s;
    logic [511:0] w_data_s;
    int rd_dly, ar_cnt;
    int ar_lat = 0;

    task automatic slave_clear();
        ar_hs = 0; ar_wait = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        rd_busy = 0; aw_got = 0; w_got = 0; rd_dly = 0; ar_cnt = 0;
        arready_m = 0; rvalid_m = 0; awready_m = 0; wready_m = 0; bvalid_m = 0;
    endtask

    initial begin
        rid_m = '0; rresp_m = '0; rlast_m = 1'b1; bid_m = '0; bresp_m = '0; rdata_m = '0;
        ar_addr_s = '0; rd_addr = '0; aw_addr_s = '0; w_strb_s = '0; w_data_s = '0; f0_seen = 0;
        slave_clear();
        forever begin
            @(negedge clk);
            if (!rst) begin
                slave_clear();
            end else begin
                if (ar_wait) begin
                    check("arvalid_hold", 64'(arvalid_m), 64'd1);
                    check("araddr_hold", araddr_m, ar_addr_s);
                end
                if (ar_hs) begin
                    check("arlen", 64'(arlen_m), 64'd0);
                    check("arsize", 64'(arsize_m), 64'd6);
                    check("araddr_align", 64'(ar_addr_s[5:0]), 64'd0);
                    rd_addr = ar_addr_s; rd_busy = 1; rd_dly = $urandom_range(0, 2);
                end
                if (r_hs) begin rvalid_m = 0; rd_busy = 0; end
                if (aw_hs) aw_got = 1;
                if (w_hs) begin w_got = 1; check("wlast", 64'(wlast_m), 64'd1); end
                if (b_hs) bvalid_m = 0;
                if (aw_got && w_got && !bvalid_m) begin
                    check("awaddr_align", 64'(aw_addr_s[5:0]), 64'd0);
                    check("awlen", 64'(awlen_m), 64'd0);
                    check("awsize", 64'(awsize_m), 64'd6);
                    check("wdata_repl", 64'(w_data_s[511:480]), 64'(w_data_s[31:0]));
                    for (int i = 0; i < 16; i++)
                        if (w_strb_s[4 * i +: 4] == 4'hF) mem[(aw_addr_s >> 2) + 64'(i)] = w_data_s[32 * i +: 32];
                    if (w_strb_s == 64'hF0) f0_seen = 1;
                    bvalid_m = 1; aw_got = 0; w_got = 0;
                end
                if (arvalid_m && !rd_busy) begin
                    ar_cnt++;
                    arready_m = (ar_cnt > ar_lat);
                end else begin
                    ar_cnt = 0; arready_m = 0;
                end
                if (rd_busy && !rvalid_m) begin
                    if (rd_dly == 0) begin
                        for (int i = 0; i < 16; i++) rdata_m[32 * i +: 32] = rd_word((rd_addr >> 2) + 64'(i));
                        rvalid_m = 1;
                    end else rd_dly--;
                end
                awready_m = awvalid_m && !aw_got && ($urandom_range(0, 1) == 1);
                wready_m  = wvalid_m && !w_got && ($urandom_range(0, 1) == 1);
                ar_hs = arvalid_m && arready_m;
                ar_wait = arvalid_m && !arready_m;
                ar_addr_s = araddr_m;
                r_hs = rvalid_m && rready_m;
                aw_hs = awvalid_m && awready_m;
                if (aw_hs) aw_addr_s = awaddr_m;
                w_hs = wvalid_m && wready_m;
                if (w_hs) begin w_data_s = wdata_m; w_strb_s = wstrb_m; end
                b_hs = bvalid_m && bready_m;
            end
        end
    end

    // Response monitor pops the scoreboard
    always @(negedge clk) begin
        if (rst && softreg_resp_valid) begin
            if (sb.size() == 0) check("resp_spurious", 64'(softreg_resp_valid), 64'd0);
            else check("resp_data", softreg_resp_data, sb.pop_front());
        end
    end

    task automatic sr_cmd(input logic wr, input logic [31:0] a, input logic [63:0] d);
        @(negedge clk);
        softreg_req_valid = 1; softreg_req_isWrite = wr; softreg_req_addr = a; softreg_req_data = d;
        @(negedge clk);
        softreg_req_valid = 0; softreg_req_isWrite = 0;
    endtask

    task automatic sr_read(input logic [31:0] a, input logic [63:0] exp);
        sb.push_back(exp);
        sr_cmd(1'b0, a, 64'd0);
    endtask

    task automatic wait_resp(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
        check("resp_timeout", 64'(sb.size()), 64'd0);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 0;
        repeat (3) @(negedge clk);
        rst = 1;
    endtask

    task automatic program_and_start();
        sr_cmd(1'b1, 32'h00, 64'(g_n));
        sr_cmd(1'b1, 32'h08, (g_n > 0) ? 64'(g_end[g_n - 1]) : 64'd0);
        sr_cmd(1'b1, 32'h10, VADDR);
        sr_cmd(1'b1, 32'h18, IEADDR);
        sr_cmd(1'b1, 32'h20, WADDR0);
        sr_cmd(1'b1, 32'h28, WADDR1);
        sr_cmd(1'b1, 32'h30, 64'd0);
    endtask

    task automatic set_graph4();
        g_n = 4;
        g_end[0] = 1; g_end[1] = 2; g_end[2] = 5; g_end[3] = 5;
        g_inv[0] = 32'h8000; g_inv[1] = 32'h10000; g_inv[2] = 32'h10000; g_inv[3] = 32'h10000;
        g_edge[0] = 2; g_edge[1] = 0; g_edge[2] = 0; g_edge[3] = 1; g_edge[4] = 3;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout tests=%0d", n_tests);
        $fatal(1, "bench timeout");
    end

    initial begin
        softreg_req_valid = 0; softreg_req_isWrite = 0; softreg_req_addr = '0; softreg_req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_arvalid", 64'(arvalid_m), 64'd0);
        check("rst_rready", 64'(rready_m), 64'd0);
        check("rst_awvalid", 64'(awvalid_m), 64'd0);
        check("rst_wvalid", 64'(wvalid_m), 64'd0);
        check("rst_bready", 64'(bready_m), 64'd0);
        check("rst_resp_valid", 64'(softreg_resp_valid), 64'd0);
        check("rst_resp_data", softreg_resp_data, 64'd0);
        rst = 1;

        // Register readback depends on build option
        sr_cmd(1'b1, 32'h00, 64'd10);
        sr_read(32'h00, RB_EXP);
        wait_resp(50);

        // Two-vertex cycle with arready stalls; DONE_ALL issued before completion
        do_reset();
        ar_lat = 5; f0_seen = 0;
        g_n = 2; g_end[0] = 1; g_end[1] = 2; g_inv[0] = 32'h10000; g_inv[1] = 32'h10000;
        g_edge[0] = 1; g_edge[1] = 0;
        load_graph();
        program_and_start();
        sr_read(32'h38, 64'h20000);
        wait_resp(20000);
        check("two_r0", 64'(rd_word((RES_BUF >> 2) + 64'd0)), 64'h10000);
        check("two_r1", 64'(rd_word((RES_BUF >> 2) + 64'd1)), 64'h10000);
        check("wstrb_f0_seen", 64'(f0_seen), 64'd1);
        ar_lat = 0;

        // Single sink vertex, read after completion
        do_reset();
        g_n = 1; g_end[0] = 0; g_inv[0] = 32'h0;
        load_graph();
        program_and_start();
        repeat (400) @(negedge clk);
        sr_read(32'h38, 64'h2666);
        wait_resp(5000);
        check("one_rank", 64'(rd_word(RES_BUF >> 2)), 64'h2666);

        // Four-vertex graph against the reference model
        do_reset();
        set_graph4();
        load_graph();
        run_model();
        program_and_start();
        sr_read(32'h38, m_total);
        wait_resp(20000);
        for (int v = 0; v < 4; v++)
            check($sformatf("g4_rank%0d", v), 64'(rd_word((RES_BUF >> 2) + 64'(v))), 64'(m_rank[v]));

        // Reset in the middle of a run, then a clean rerun
        do_reset();
        load_graph();
        program_and_start();
        repeat (300) @(negedge clk);
        rst = 0;
        #1;
        check("mid_arvalid", 64'(arvalid_m), 64'd0);
        check("mid_rready", 64'(rready_m), 64'd0);
        check("mid_awvalid", 64'(awvalid_m), 64'd0);
        check("mid_wvalid", 64'(wvalid_m), 64'd0);
        check("mid_bready", 64'(bready_m), 64'd0);
        check("mid_resp_valid", 64'(softreg_resp_valid), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1;
        load_graph();
        program_and_start();
        sr_read(32'h38, m_total);
        wait_resp(20000);

        // Empty graph finishes immediately with zero total
        do_reset();
        g_n = 0;
        load_graph();
        program_and_start();
        sr_read(32'h38, 64'd0);
        wait_resp(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
